// File: rtl/accum_differentiator.sv
// First-difference recovery of accumulator input samples from a running-sum stream.
// Optional build macro DELTA_SAT_EN clamps out-of-range deltas instead of wrapping them.
module accum_differentiator #(
  parameter int IN_W       = 13,
  parameter int SUM_W      = 20,
  parameter int FRAME_LEN  = 11,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             s_valid,
  input  logic [SUM_W-1:0] s_data,
  input  logic             s_first,
  output logic             s_ready,
  output logic             m_valid,
  output logic [IN_W-1:0]  m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic [1:0]       err,
  output logic [3:0]       sample_idx
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0]    DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0]    PTR_MAX  = PW'(FIFO_DEPTH - 1);
  localparam logic [3:0]       LAST_IDX = 4'(FRAME_LEN - 1);
  localparam logic [SUM_W-1:0] MAX_A    = SUM_W'((1 << IN_W) - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [SUM_W-1:0] prev;
  logic [CW-1:0]    count;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [IN_W-1:0]  mem_data [FIFO_DEPTH];
  logic             mem_last [FIFO_DEPTH];

  logic             accept;
  logic             pop;
  logic             do_push;
  logic [SUM_W:0]   prev_term;
  logic [SUM_W:0]   delta;
  logic             d_neg;
  logic             d_over;
  logic [IN_W-1:0]  push_data;
  logic [3:0]       next_idx;
  logic             sync_err;
  logic             range_err;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  assign s_ready = ce & (count < DEPTH_C) & ~rst;
  assign accept  = ce & s_valid & s_ready;
  assign m_valid = (count != '0);
  assign pop     = ce & m_valid & m_ready;
  assign m_data  = m_valid ? mem_data[rd_ptr] : '0;
  assign m_last  = m_valid ? mem_last[rd_ptr] : 1'b0;

  // Delta is formed one bit wider than the sum so a falling sum shows up as negative.
  always_comb begin
    prev_term = '0;
    if (state == RUN && !s_first)
      prev_term = {1'b0, prev};
    delta  = {1'b0, s_data} - prev_term;
    d_neg  = delta[SUM_W];
    d_over = ~d_neg & (delta[SUM_W-1:0] > MAX_A);
`ifdef DELTA_SAT_EN
    if (d_neg)
      push_data = '0;
    else if (d_over)
      push_data = MAX_A[IN_W-1:0];
    else
      push_data = delta[IN_W-1:0];
`else
    push_data = delta[IN_W-1:0];
`endif
    if (s_first)
      next_idx = '0;
    else if (sample_idx == LAST_IDX)
      next_idx = LAST_IDX;
    else
      next_idx = sample_idx + 1'b1;
    do_push   = accept & (s_first | (state == RUN));
    range_err = do_push & (d_neg | d_over);
    sync_err  = accept & (((state == IDLE) & ~s_first) |
                          ((state == RUN) & s_first & (sample_idx != LAST_IDX)) |
                          ((state == RUN) & ~s_first & (sample_idx == LAST_IDX)));
  end

  // Frame tracking, sticky error flags and the output FIFO share one register block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev       <= '0;
      sample_idx <= '0;
      err        <= '0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      err <= err | {sync_err, range_err};
      if (do_push) begin
        mem_data[wr_ptr] <= push_data;
        mem_last[wr_ptr] <= (next_idx == LAST_IDX);
        wr_ptr           <= ptr_inc(wr_ptr);
        prev             <= s_data;
        sample_idx       <= next_idx;
        state            <= RUN;
      end
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
